// File: rtl/game_pkg.sv
// Shared definitions for the guess-entry and game controller: key codes,
// the empty-slot code and the entry state machine encoding.
package game_pkg;

    localparam int          NUM_DIGITS = 3;
    localparam logic [3:0]  KEY_BKSP   = 4'hA;
    localparam logic [3:0]  KEY_CLR    = 4'hB;
    localparam logic [3:0]  KEY_ENT    = 4'hC;
    localparam logic [3:0]  BLANK      = 4'hF;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2,
        COMMIT  = 2'd3
    } entry_state_t;

    // Resting state implied by a digit count (COMMIT is never a resting state).
    function automatic entry_state_t state_for_count(input logic [1:0] count);
        entry_state_t st;
        if (count == 2'd0) begin
            st = EMPTY;
        end else if (count == 2'd3) begin
            st = FULL;
        end else begin
            st = PARTIAL;
        end
        return st;
    endfunction

endpackage

// File: rtl/num_entry_keyclass.sv
// Combinational key decoder: splits a key code into its command class and
// flags a digit that already sits in one of the filled slots.
module num_entry_keyclass
    import game_pkg::*;
(
    input  logic [3:0]                  key,
    input  logic [NUM_DIGITS-1:0][3:0]  slots,
    input  logic [1:0]                  count,
    output logic                        is_digit,
    output logic                        is_bksp,
    output logic                        is_clr,
    output logic                        is_ent,
    output logic                        dup_hit
);

    logic [NUM_DIGITS-1:0] hit_vec;

    assign is_digit = (key <= 4'd9);
    assign is_bksp  = (key == KEY_BKSP);
    assign is_clr   = (key == KEY_CLR);
    assign is_ent   = (key == KEY_ENT);

    // Only slots below the count are considered filled, so a BLANK code that
    // happens to be a digit value never produces a false duplicate.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_hit
            assign hit_vec[gi] = (count > 2'(gi)) && (slots[gi] == key);
        end
    endgenerate

    assign dup_hit = is_digit && (|hit_vec);

endmodule

// File: rtl/num_entry.sv
// Three-digit guess entry: collects keypad digits with backspace/clear/enter
// and hands the completed guess downstream with a one-cycle ready strobe.
module num_entry
    import game_pkg::*;
#(
    parameter bit          UNIQUE = 1'b1,
    parameter logic [3:0]  BLANK  = game_pkg::BLANK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  iKey,
    input  logic        iKeyVld,
    input  logic        iBusy,
    output logic [3:0]  oNum1,
    output logic [3:0]  oNum2,
    output logic [3:0]  oNum3,
    output logic        oNumRdy,
    output logic [1:0]  oCount,
    output logic        oErr
);

    entry_state_t                 state_reg,  state_next;
    logic [NUM_DIGITS-1:0][3:0]   slots_reg,  slots_next;
    logic [1:0]                   count_reg,  count_next;
    logic                         err_reg,    err_next;
    logic                         rdy_reg,    rdy_next;

    logic is_digit, is_bksp, is_clr, is_ent, dup_hit;
    logic accept;

    num_entry_keyclass u_keyclass (
        .key      (iKey),
        .slots    (slots_reg),
        .count    (count_reg),
        .is_digit (is_digit),
        .is_bksp  (is_bksp),
        .is_clr   (is_clr),
        .is_ent   (is_ent),
        .dup_hit  (dup_hit)
    );

    assign accept = iKeyVld && !iBusy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            slots_reg <= {NUM_DIGITS{BLANK}};
            count_reg <= 2'd0;
            err_reg   <= 1'b0;
            rdy_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            slots_reg <= slots_next;
            count_reg <= count_next;
            err_reg   <= err_next;
            rdy_reg   <= rdy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        slots_next = slots_reg;
        count_next = count_reg;
        err_next   = 1'b0;
        rdy_next   = 1'b0;

        case (state_reg)
            // Digits stay on the outputs for the ready cycle; any key
            // arriving now is dropped without an error.
            COMMIT: begin
                state_next = EMPTY;
                slots_next = {NUM_DIGITS{BLANK}};
                count_next = 2'd0;
            end

            default: begin
                if (accept) begin
                    if (is_digit) begin
                        if ((count_reg == 2'd3) || (UNIQUE && dup_hit)) begin
                            err_next = 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (i == int'(count_reg)) begin
                                    slots_next[i] = iKey;
                                end
                            end
                            count_next = count_reg + 2'd1;
                            state_next = state_for_count(count_reg + 2'd1);
                        end
                    end else if (is_bksp) begin
                        if (count_reg == 2'd0) begin
                            err_next = 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (i == int'(count_reg) - 1) begin
                                    slots_next[i] = BLANK;
                                end
                            end
                            count_next = count_reg - 2'd1;
                            state_next = state_for_count(count_reg - 2'd1);
                        end
                    end else if (is_clr) begin
                        slots_next = {NUM_DIGITS{BLANK}};
                        count_next = 2'd0;
                        state_next = EMPTY;
                    end else if (is_ent) begin
                        if (state_reg == FULL) begin
                            state_next = COMMIT;
                            rdy_next   = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                    // Codes D..F fall through untouched.
                end
            end
        endcase
    end

    assign oNum1   = slots_reg[0];
    assign oNum2   = slots_reg[1];
    assign oNum3   = slots_reg[2];
    assign oCount  = count_reg;
    assign oErr    = err_reg;
    assign oNumRdy = rdy_reg;

endmodule

// File: tb/tb_num_entry.sv
// Scoreboard bench for num_entry: the driver queues the expected registered
// outputs for every cycle it drives, a negedge monitor pops and compares.
module tb_num_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key = 4'h0;
    logic       vld_a = 1'b0;
    logic       vld_b = 1'b0;
    logic       busy = 1'b0;

    logic [3:0] num1_a, num2_a, num3_a, num1_b, num2_b, num3_b;
    logic [1:0] count_a, count_b;
    logic       rdy_a, rdy_b, err_a, err_b;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit         which;
        logic [3:0] n1, n2, n3;
        logic [1:0] cnt;
        logic       rdy, err;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    num_entry #(.UNIQUE(1'b1), .BLANK(4'hF)) dut_a (
        .clk(clk), .reset(reset), .iKey(key), .iKeyVld(vld_a), .iBusy(busy),
        .oNum1(num1_a), .oNum2(num2_a), .oNum3(num3_a),
        .oNumRdy(rdy_a), .oCount(count_a), .oErr(err_a)
    );

    num_entry #(.UNIQUE(1'b0), .BLANK(4'hF)) dut_b (
        .clk(clk), .reset(reset), .iKey(key), .iKeyVld(vld_b), .iBusy(busy),
        .oNum1(num1_b), .oNum2(num2_b), .oNum3(num3_b),
        .oNumRdy(rdy_b), .oCount(count_b), .oErr(err_b)
    );

    task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s.%s got %h expected %h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] a1, a2, a3;
            logic [1:0] ac;
            logic       ar, ae;
            e = exp_q.pop_front();
            if (e.which) begin
                a1 = num1_b; a2 = num2_b; a3 = num3_b; ac = count_b; ar = rdy_b; ae = err_b;
            end else begin
                a1 = num1_a; a2 = num2_a; a3 = num3_a; ac = count_a; ar = rdy_a; ae = err_a;
            end
            chk(e.name, "num1", a1, e.n1);
            chk(e.name, "num2", a2, e.n2);
            chk(e.name, "num3", a3, e.n3);
            chk(e.name, "count", {2'b00, ac}, {2'b00, e.cnt});
            chk(e.name, "rdy", {3'b000, ar}, {3'b000, e.rdy});
            chk(e.name, "err", {3'b000, ae}, {3'b000, e.err});
            $display("%s: dut%s num=%h%h%h cnt=%0d rdy=%b err=%b", e.name,
                     e.which ? "B" : "A", a1, a2, a3, ac, ar, ae);
        end
    end

    // One clock of stimulus; the expectation applies to outputs after this edge.
    task automatic step(input bit w, input logic r, input logic [3:0] k, input logic v,
                        input logic b, input logic [3:0] e1, input logic [3:0] e2,
                        input logic [3:0] e3, input logic [1:0] ec, input logic erdy,
                        input logic eerr, input string nm);
        exp_t e;
        reset = r;
        key   = k;
        vld_a = v && !w;
        vld_b = v && w;
        busy  = b;
        @(posedge clk);
        e.which = w; e.n1 = e1; e.n2 = e2; e.n3 = e3; e.cnt = ec;
        e.rdy = erdy; e.err = eerr; e.name = nm;
        exp_q.push_back(e);
        #1;
        reset = 1'b0;
        vld_a = 1'b0;
        vld_b = 1'b0;
        busy  = 1'b0;
    endtask

    localparam logic [3:0] F = 4'hF;
    localparam logic [3:0] BK = 4'hA;
    localparam logic [3:0] CL = 4'hB;
    localparam logic [3:0] EN = 4'hC;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset state of both instances
        step(0, 1, 0, 0, 0, F, F, F, 0, 0, 0, "reset_a");
        step(1, 0, 0, 0, 0, F, F, F, 0, 0, 0, "reset_b");

        // Basic entry and commit
        step(0, 0, 4'd3, 1, 0, 3, F, F, 1, 0, 0, "t1_key3");
        step(0, 0, 4'd7, 1, 0, 3, 7, F, 2, 0, 0, "t1_key7");
        step(0, 0, 4'd1, 1, 0, 3, 7, 1, 3, 0, 0, "t1_key1");
        step(0, 0, EN,   1, 0, 3, 7, 1, 3, 1, 0, "t1_enter");
        step(0, 0, 0,    0, 0, F, F, F, 0, 0, 0, "t1_after");

        // Duplicate rejection (A) versus repeats allowed (B)
        step(0, 0, 4'd5, 1, 0, 5, F, F, 1, 0, 0, "t2_a_5");
        step(0, 0, 4'd5, 1, 0, 5, F, F, 1, 0, 1, "t2_a_dup");
        step(0, 0, 0,    0, 0, 5, F, F, 1, 0, 0, "t2_a_errpulse");
        step(0, 0, CL,   1, 0, F, F, F, 0, 0, 0, "t2_a_clr");
        step(1, 0, 4'd5, 1, 0, 5, F, F, 1, 0, 0, "t2_b_5");
        step(1, 0, 4'd5, 1, 0, 5, 5, F, 2, 0, 0, "t2_b_5again");
        step(1, 0, CL,   1, 0, F, F, F, 0, 0, 0, "t2_b_clr");

        // Backspace editing, backspace on empty
        step(0, 0, 4'd2, 1, 0, 2, F, F, 1, 0, 0, "t3_key2");
        step(0, 0, 4'd8, 1, 0, 2, 8, F, 2, 0, 0, "t3_key8");
        step(0, 0, BK,   1, 0, 2, F, F, 1, 0, 0, "t3_bksp");
        step(0, 0, 4'd4, 1, 0, 2, 4, F, 2, 0, 0, "t3_key4");
        step(0, 0, 4'd9, 1, 0, 2, 4, 9, 3, 0, 0, "t3_key9");
        step(0, 0, BK,   1, 0, 2, 4, F, 2, 0, 0, "t3_bksp_full");
        step(0, 0, 4'd9, 1, 0, 2, 4, 9, 3, 0, 0, "t3_key9b");
        step(0, 0, EN,   1, 0, 2, 4, 9, 3, 1, 0, "t3_enter");
        step(0, 0, 0,    0, 0, F, F, F, 0, 0, 0, "t3_after");
        step(0, 0, BK,   1, 0, F, F, F, 0, 0, 1, "t3_bksp_empty");

        // Enter on a partial entry, then clear
        step(0, 0, 4'd6, 1, 0, 6, F, F, 1, 0, 0, "t4_key6");
        step(0, 0, EN,   1, 0, 6, F, F, 1, 0, 1, "t4_enter_err");
        step(0, 0, 0,    0, 0, 6, F, F, 1, 0, 0, "t4_hold");
        step(0, 0, CL,   1, 0, F, F, F, 0, 0, 0, "t4_clr");
        step(0, 0, CL,   1, 0, F, F, F, 0, 0, 0, "t4_clr_empty");

        // Overflow digit, busy, ignored codes
        step(0, 0, 4'd1, 1, 0, 1, F, F, 1, 0, 0, "t5_key1");
        step(0, 0, 4'd2, 1, 0, 1, 2, F, 2, 0, 0, "t5_key2");
        step(0, 0, 4'd3, 1, 0, 1, 2, 3, 3, 0, 0, "t5_key3");
        step(0, 0, 4'd4, 1, 0, 1, 2, 3, 3, 0, 1, "t5_key4_full");
        step(0, 0, 4'd5, 1, 1, 1, 2, 3, 3, 0, 0, "t5_busy_digit");
        step(0, 0, EN,   1, 1, 1, 2, 3, 3, 0, 0, "t5_busy_enter");
        step(0, 0, CL,   1, 1, 1, 2, 3, 3, 0, 0, "t5_busy_clr");
        step(0, 0, 4'hD, 1, 0, 1, 2, 3, 3, 0, 0, "t5_code_d");
        step(0, 0, 4'hF, 1, 0, 1, 2, 3, 3, 0, 0, "t5_code_f");
        step(0, 0, CL,   1, 0, F, F, F, 0, 0, 0, "t5_clr");

        // Reset mid-entry, then commit with a key in the commit cycle
        step(0, 0, 4'd1, 1, 0, 1, F, F, 1, 0, 0, "t6_key1");
        step(0, 0, 4'd2, 1, 0, 1, 2, F, 2, 0, 0, "t6_key2");
        step(0, 1, 4'd3, 1, 0, F, F, F, 0, 0, 0, "t6_reset");
        step(0, 0, 4'd9, 1, 0, 9, F, F, 1, 0, 0, "t6_key9");
        step(0, 0, 4'd8, 1, 0, 9, 8, F, 2, 0, 0, "t6_key8");
        step(0, 0, 4'd7, 1, 0, 9, 8, 7, 3, 0, 0, "t6_key7");
        step(0, 0, EN,   1, 0, 9, 8, 7, 3, 1, 0, "t6_enter");
        step(0, 0, 4'd5, 1, 0, F, F, F, 0, 0, 0, "t6_commit_drop");
        step(0, 0, 0,    0, 0, F, F, F, 0, 0, 0, "t6_idle");

        // Reset during the commit cycle suppresses any later strobe
        step(0, 0, 4'd4, 1, 0, 4, F, F, 1, 0, 0, "t7_key4");
        step(0, 0, 4'd5, 1, 0, 4, 5, F, 2, 0, 0, "t7_key5");
        step(0, 0, 4'd6, 1, 0, 4, 5, 6, 3, 0, 0, "t7_key6");
        step(0, 0, EN,   1, 0, 4, 5, 6, 3, 1, 0, "t7_enter");
        step(0, 1, 0,    0, 0, F, F, F, 0, 0, 0, "t7_reset_commit");
        step(0, 0, 0,    0, 0, F, F, F, 0, 0, 0, "t7_idle");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain pending %0d expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
